ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Instruction fetch front end that produces the instruction/address pair consumed by the IF/ID pipeline register.
- Owns the PC and drives a synchronous-read instruction ROM (data one cycle after request).
- Redirects on a jump from the execute unit.
- Stalls on the ctrl hold flag without losing the instruction in flight, using a one-entry skid buffer.
- Sits between the instruction ROM and the IF/ID register; its output pair is what that register samples every cycle.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH (32): instruction width.
- ROM_DEPTH, default `ROM_DEPTH (4096): ROM words; ADDR_W = $clog2(ROM_DEPTH) (12).
- RESET_ADDR, default 0: first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- jump_flag_i_exu_ifu  in  1  redirect request.
- jump_addr_i_exu_ifu  in  ADDR_W  redirect target, word index.
- hold_flag_i_ctrl_ifu  in  1  stall; the instruction presented this cycle is not consumed.
- rom_en_o_ifu_rom  out  1  ROM read request.
- rom_addr_o_ifu_rom  out  ADDR_W  ROM read address.
- rom_data_i_rom_ifu  in  DATA_WIDTH  ROM data, valid the cycle after rom_en_o_ifu_rom=1.
- instr_o_ifu_ifu2idu  out  DATA_WIDTH  instruction to IF/ID.
- instr_addr_o_ifu_ifu2idu  out  ADDR_W  address of instr_o_ifu_ifu2idu.

## Operation
Registers:
- pc: next address to request.
- rsp_valid / rsp_addr: a ROM response arrives this cycle, and its address.
- skid_valid / skid_instr / skid_addr: one-entry skid buffer.

Output select (combinational), in priority order:
- rst=1: instr=`INSTR_NOP, addr=0, rom_en=0.
- skid_valid: present skid_instr / skid_addr.
- rsp_valid: present rom_data_i_rom_ifu / rsp_addr.
- Otherwise: present `INSTR_NOP with addr=rsp_addr (bubble).

Per-cycle actions, in priority order:
- rst: pc<=RESET_ADDR, rsp_valid<=0, skid_valid<=0, rsp_addr<=0.
- Jump:
  - rom_en=1, rom_addr=jump_addr (same cycle); pc<=jump_addr+1; rsp_addr<=jump_addr; rsp_valid<=1; skid_valid<=0.
  - Output this cycle is forced to `INSTR_NOP (the wrong-path instruction is squashed).
  - Jump overrides hold.
- Hold (no jump):
  - rom_en=0; pc unchanged; rsp_valid<=0.
  - If !skid_valid && rsp_valid: capture the presented instr/addr into skid.
  - If skid_valid: skid is held.
- Run (no jump, no hold):
  - rom_en=1, rom_addr=pc; pc<=pc+1; rsp_addr<=pc; rsp_valid<=1.
  - If skid_valid: skid_valid<=0 (skid is presented this cycle, which consumes it).

Rules:
- Address arithmetic is modulo ROM_DEPTH: pc=ROM_DEPTH-1 increments to 0; jump_addr+1 wraps the same way.
- States: BOOT (rsp_valid=0, skid_valid=0), RUN (rsp_valid=1), HELD (skid_valid=1), with transitions as given by the actions above.
- Hold entered from BOOT leaves skid empty; on release a NOP bubble is output while pc is requested.
- Every instruction that was presented while hold=1 is re-presented exactly once after hold falls. None is dropped or duplicated.

## Timing
- Reset release: cycle 0 outputs NOP/0 and requests RESET_ADDR; cycle 1 outputs instr@RESET_ADDR. Outputs then advance one address per cycle.
- Redirect: jump in cycle N → NOP in cycle N, target instr in N+1, target+1 in N+2.
- Hold:
  - Hold asserted in cycles H..H+k: the output during those cycles equals the instruction presented at H.
  - Cycle H+k+1 re-presents it from skid and requests pc.
  - Cycle H+k+2 outputs the next sequential instruction. Zero-bubble resume.
- Jump during a held skid: skid is discarded; the redirect takes the normal one-cycle NOP.
- rst asserted mid-stream takes effect at the next edge; outputs are forced NOP/0 combinationally while rst=1.

## Test plan
- Reset, then free-run with ROM word i = 0x1000_0000+i: cycle 0 = NOP/0; cycle n≥1 shows addr n-1, instr 0x1000_0000+(n-1); rom_addr increments by 1 per cycle.
- Hold 3 cycles while addr 5 is presented: output stays addr 5 for 3 cycles, then addr 5 once more, then 6, 7; no rom_en during hold.
- Jump to 0x200 while addr 9 is presented: that cycle NOP; then 0x200, 0x201; rom_addr=0x200 in the jump cycle.
- Jump and hold both asserted while skid holds addr 4: NOP, skid cleared, next cycle shows the jump target.
- Wrap: jump to 0xFFE; output sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Hold asserted in the first cycle after reset for 2 cycles: outputs NOP; after release, NOP then instr@RESET_ADDR; rst pulsed mid-run → next output sequence restarts at RESET_ADDR.

Source files
------------

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: owns the PC and drives the instruction ROM.
// It also redirects on jumps and holds the in-flight instruction in a one-entry skid buffer while the pipeline stalls.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROM_DEPTH
`define ROM_DEPTH 4096
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif
module ifu_prefetch #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ROM_DEPTH  = `ROM_DEPTH,
    parameter int RESET_ADDR = 0,
    localparam int ADDR_W    = $clog2(ROM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_flag_i_exu_ifu,
    input  logic [ADDR_W-1:0]     jump_addr_i_exu_ifu,
    input  logic                  hold_flag_i_ctrl_ifu,
    output logic                  rom_en_o_ifu_rom,
    output logic [ADDR_W-1:0]     rom_addr_o_ifu_rom,
    input  logic [DATA_WIDTH-1:0] rom_data_i_rom_ifu,
    output logic [DATA_WIDTH-1:0] instr_o_ifu_ifu2idu,
    output logic [ADDR_W-1:0]     instr_addr_o_ifu_ifu2idu
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(`INSTR_NOP);
    logic [ADDR_W-1:0]     pc, rsp_addr, skid_addr;
    logic                  rsp_valid, skid_valid;
    logic [DATA_WIDTH-1:0] skid_instr, sel_instr;
    logic [ADDR_W-1:0]     sel_addr;
    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(ROM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction
    always_comb begin
        sel_instr = skid_valid ? skid_instr : rsp_valid ? rom_data_i_rom_ifu : NOP;
        sel_addr = skid_valid ? skid_addr : rsp_addr;
        rom_en_o_ifu_rom = !rst && (jump_flag_i_exu_ifu || !hold_flag_i_ctrl_ifu);
        rom_addr_o_ifu_rom = jump_flag_i_exu_ifu ? jump_addr_i_exu_ifu : pc;
        instr_o_ifu_ifu2idu = (rst || jump_flag_i_exu_ifu) ? NOP : sel_instr;
        instr_addr_o_ifu_ifu2idu = rst ? '0 : sel_addr;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_ADDR);
            rsp_valid <= 1'b0;
            skid_valid <= 1'b0;
            rsp_addr <= '0;
        end else if (jump_flag_i_exu_ifu) begin
            pc <= inc(jump_addr_i_exu_ifu);
            rsp_addr <= jump_addr_i_exu_ifu;
            rsp_valid <= 1'b1;
            skid_valid <= 1'b0;
        end else if (hold_flag_i_ctrl_ifu) begin
            rsp_valid <= 1'b0;
            if (!skid_valid && rsp_valid) begin
                skid_valid <= 1'b1;
                skid_instr <= rom_data_i_rom_ifu;
                skid_addr <= rsp_addr;
            end
        end else begin
            pc <= inc(pc);
            rsp_addr <= pc;
            rsp_valid <= 1'b1;
            skid_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scenarios plus random jump/hold/reset traffic, checked every cycle against a stream-level model.
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif
module tb_ifu_prefetch;
    localparam int AW = 12;
    localparam int DEPTH = 4096;
    localparam logic [31:0] NOP = `INSTR_NOP;
    logic clk = 0, rst = 1, jump = 0, hold = 0;
    logic [AW-1:0] jaddr = '0;
    logic rom_en;
    logic [AW-1:0] rom_addr, out_addr;
    logic [31:0] rom_data = '0, out_instr;
    int n_chk = 0, n_fail = 0;

    ifu_prefetch dut (
        .clk(clk), .rst(rst),
        .jump_flag_i_exu_ifu(jump), .jump_addr_i_exu_ifu(jaddr),
        .hold_flag_i_ctrl_ifu(hold),
        .rom_en_o_ifu_rom(rom_en), .rom_addr_o_ifu_rom(rom_addr),
        .rom_data_i_rom_ifu(rom_data),
        .instr_o_ifu_ifu2idu(out_instr), .instr_addr_o_ifu_ifu2idu(out_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= word(int'(rom_addr));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: what was fetched last cycle, which instruction is still owed after a stall, next fetch address.
    bit m_fetched = 0, m_owed = 0;
    int m_fetch_addr = 0, m_owed_addr = 0, m_pc = 0;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_instr", out_instr, NOP);
            chk("rst_addr", 32'(out_addr), 0);
            chk("rst_en", 32'(rom_en), 0);
            m_fetched = 0; m_owed = 0; m_fetch_addr = 0; m_pc = 0;
        end else begin
            int show;
            bit real_instr;
            show = m_owed ? m_owed_addr : m_fetch_addr;
            real_instr = m_owed || m_fetched;
            if (jump) chk("jump_squash", out_instr, NOP);
            else begin
                chk("out_addr", 32'(out_addr), 32'(show));
                chk("out_instr", out_instr, real_instr ? word(show) : NOP);
            end
            chk("rom_en", 32'(rom_en), 32'(jump || !hold));
            if (jump) chk("rom_addr_jump", 32'(rom_addr), 32'(jaddr));
            else if (!hold) chk("rom_addr", 32'(rom_addr), 32'(m_pc));
            if (jump) begin
                m_fetched = 1; m_fetch_addr = int'(jaddr); m_pc = (int'(jaddr) + 1) % DEPTH; m_owed = 0;
            end else if (hold) begin
                if (!m_owed && m_fetched) begin m_owed = 1; m_owed_addr = m_fetch_addr; end
                m_fetched = 0;
            end else begin
                m_fetched = 1; m_fetch_addr = m_pc; m_pc = (m_pc + 1) % DEPTH; m_owed = 0;
            end
        end
    end

    // Drive one cycle and pin the output with a literal expectation (ea < 0: NOP expected).
    task automatic cyc(input logic j, input int ja, input logic h, input int ea);
        jump = j; jaddr = AW'(ja); hold = h;
        @(negedge clk);
        if (ea < 0) chk("lit_nop", out_instr, NOP);
        else begin
            chk("lit_addr", 32'(out_addr), 32'(ea));
            chk("lit_instr", out_instr, word(ea));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cyc(0, 0, 0, -1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, i);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5);
        cyc(0, 0, 0, 5);
        cyc(0, 0, 0, 6);
        cyc(0, 0, 0, 7);
        cyc(0, 0, 0, 8);
        cyc(1, 'h200, 0, -1);
        cyc(0, 0, 0, 'h200);
        cyc(0, 0, 0, 'h201);
        cyc(0, 0, 1, 'h202);
        cyc(0, 0, 1, 'h202);
        cyc(1, 'hFFE, 1, -1);
        cyc(0, 0, 0, 'hFFE);
        cyc(0, 0, 0, 'hFFF);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        cyc(0, 0, 1, -1);
        cyc(0, 0, 1, -1);
        cyc(0, 0, 0, -1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            jump = ($urandom_range(0, 15) == 0);
            hold = ($urandom_range(0, 3) == 0);
            jaddr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(DEPTH - 4, DEPTH - 1)) : AW'($urandom);
            @(posedge clk); #1;
        end
        rst = 0; jump = 0; hold = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
